// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

    // Receiver FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Active-high a..g patterns for the ten decimal digits
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] BAD_CODE   = 4'hE;

    // Number of active (low) anode enables
    function automatic logic [2:0] low_count(input logic [3:0] an);
        return {2'b00, ~an[0]} + {2'b00, ~an[1]} + {2'b00, ~an[2]} + {2'b00, ~an[3]};
    endfunction

    // Index of the lowest active anode; only meaningful when exactly one is low
    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        if (!an[0])      idx = 2'd0;
        else if (!an[1]) idx = 2'd1;
        else if (!an[2]) idx = 2'd2;
        else if (!an[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment pattern to BCD code decoder (blank -> F, illegal -> E).
// Latency: purely combinational.
// Backpressure: none.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] code,
    output logic       ok
);

    // Map legal digit shapes to their value; everything unknown flags not-ok
    always_comb begin
        code = BAD_CODE;
        ok   = 1'b0;
        case (pat)
            SEG_0:     begin code = 4'd0;       ok = 1'b1; end
            SEG_1:     begin code = 4'd1;       ok = 1'b1; end
            SEG_2:     begin code = 4'd2;       ok = 1'b1; end
            SEG_3:     begin code = 4'd3;       ok = 1'b1; end
            SEG_4:     begin code = 4'd4;       ok = 1'b1; end
            SEG_5:     begin code = 4'd5;       ok = 1'b1; end
            SEG_6:     begin code = 4'd6;       ok = 1'b1; end
            SEG_7:     begin code = 4'd7;       ok = 1'b1; end
            SEG_8:     begin code = 4'd8;       ok = 1'b1; end
            SEG_9:     begin code = 4'd9;       ok = 1'b1; end
            SEG_BLANK: begin code = BLANK_CODE; ok = 1'b1; end
            default:   begin code = BAD_CODE;   ok = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receives a multiplexed 4-digit 7-seg display scan and latches whole frames.
// Latency: capture SETTLE+1 cycles after the synchronized input settles; frame out 2 cycles after last capture.
// Backpressure: none; the display is sampled every cycle and frames are overwritten.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [6:0]  seg,
    input  logic        DP,
    output logic [15:0] digits,
    output logic [3:0]  digit_ok,
    output logic [6:0]  value,
    output logic        value_ok,
    output logic        frame_strb,
    output logic        err_multi,
    output logic        stale
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [TW-1:0] STALE_MAX   = TW'(TIMEOUT);

    // Synchronizers plus one extra stage used for change detection
    logic [3:0]      an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    logic [6:0]      seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic            dp_s1_q, dp_s1_d, dp_s2_unused_q, dp_s2_unused_d;

    state_t          state_q, state_d;
    logic [CW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [CW-1:0]   multi_cnt_q, multi_cnt_d;
    logic [TW-1:0]   stale_cnt_q, stale_cnt_d;

    // Shadow frame being assembled, one slot per digit
    logic [3:0][3:0] shadow_code_q, shadow_code_d;
    logic [3:0]      shadow_ok_q, shadow_ok_d;
    logic [3:0]      seen_q, seen_d;

    logic [15:0]     digits_q, digits_d;
    logic [3:0]      digit_ok_q, digit_ok_d;
    logic [6:0]      value_q, value_d;
    logic            value_ok_q, value_ok_d;
    logic            frame_strb_q, frame_strb_d;
    logic            err_multi_q, err_multi_d;

    logic            an_changed, in_changed, one_low, multi_low, settle_done;
    logic            capture_en, settle_run;
    logic [1:0]      act_idx;
    logic [6:0]      seg_act;
    logic [3:0]      dec_code;
    logic            dec_ok;
    logic [6:0]      frame_value;
    logic            frame_value_ok;

    assign an_changed  = (an_s2_q != an_prev_q);
    assign in_changed  = an_changed || (seg_s2_q != seg_prev_q);
    assign one_low     = (low_count(an_s2_q) == 3'd1);
    assign multi_low   = (low_count(an_s2_q) >= 3'd2);
    assign act_idx     = low_index(an_s2_q);
    assign seg_act     = ~seg_s2_q;
    assign settle_done = (state_q == ST_SETTLE) && !in_changed && (settle_cnt_q == SETTLE_LAST);

    // Low two digits of the shadow frame as a binary number
    assign frame_value    = {3'b000, shadow_code_q[1]} * 7'd10 + {3'b000, shadow_code_q[0]};
    assign frame_value_ok = shadow_ok_q[1] && shadow_ok_q[0]
                          && (shadow_code_q[1] <= 4'd9) && (shadow_code_q[0] <= 4'd9);

    seg7_decode u_decode (
        .pat  (seg_act),
        .code (dec_code),
        .ok   (dec_ok)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: wait for one anode, let it settle, capture once, hold until it moves
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (one_low) state_d = ST_SETTLE;
            ST_SETTLE:  if (!one_low) state_d = ST_IDLE;
                        else if (settle_done) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (an_changed) state_d = one_low ? ST_SETTLE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture_en = (state_q == ST_CAPTURE);
        settle_run = (state_q == ST_SETTLE);
    end

    // Datapath next values: sync, counters, shadow frame and output latch
    always_comb begin
        an_s1_d        = AN;
        an_s2_d        = an_s1_q;
        an_prev_d      = an_s2_q;
        seg_s1_d       = seg;
        seg_s2_d       = seg_s1_q;
        seg_prev_d     = seg_s2_q;
        dp_s1_d        = DP;
        dp_s2_unused_d = dp_s1_q;

        // Settle counter restarts on any change and only runs while settling
        settle_cnt_d = '0;
        if (settle_run && !in_changed && (settle_cnt_q != SETTLE_LAST))
            settle_cnt_d = settle_cnt_q + CW'(1);

        // Consecutive multi-anode cycles; a full settle window of them is sticky
        multi_cnt_d = '0;
        err_multi_d = err_multi_q;
        if (multi_low) begin
            if (multi_cnt_q == SETTLE_LAST) begin
                multi_cnt_d = multi_cnt_q;
                err_multi_d = 1'b1;
            end else begin
                multi_cnt_d = multi_cnt_q + CW'(1);
            end
        end

        // Saturating cycles-since-capture counter
        stale_cnt_d = stale_cnt_q;
        if (capture_en)                    stale_cnt_d = '0;
        else if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + TW'(1);

        shadow_code_d = shadow_code_q;
        shadow_ok_d   = shadow_ok_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        digit_ok_d    = digit_ok_q;
        value_d       = value_q;
        value_ok_d    = value_ok_q;
        frame_strb_d  = 1'b0;

        // A complete shadow frame is published as one coherent update
        if (seen_q == 4'hF) begin
            digits_d     = shadow_code_q;
            digit_ok_d   = shadow_ok_q;
            value_ok_d   = frame_value_ok;
            value_d      = frame_value_ok ? frame_value : 7'd0;
            frame_strb_d = 1'b1;
            seen_d       = '0;
        end

        // Last capture of a digit wins within a frame
        if (capture_en) begin
            shadow_code_d[act_idx] = dec_code;
            shadow_ok_d[act_idx]   = dec_ok;
            seen_d[act_idx]        = 1'b1;
        end
    end

    // All state flops; synchronizers reset to the idle (all-high) level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1_q        <= '1;
            an_s2_q        <= '1;
            an_prev_q      <= '1;
            seg_s1_q       <= '1;
            seg_s2_q       <= '1;
            seg_prev_q     <= '1;
            dp_s1_q        <= 1'b1;
            dp_s2_unused_q <= 1'b1;
            settle_cnt_q   <= '0;
            multi_cnt_q    <= '0;
            stale_cnt_q    <= '0;
            shadow_code_q  <= '0;
            shadow_ok_q    <= '0;
            seen_q         <= '0;
            digits_q       <= 16'hFFFF;
            digit_ok_q     <= '0;
            value_q        <= '0;
            value_ok_q     <= 1'b0;
            frame_strb_q   <= 1'b0;
            err_multi_q    <= 1'b0;
        end else begin
            an_s1_q        <= an_s1_d;
            an_s2_q        <= an_s2_d;
            an_prev_q      <= an_prev_d;
            seg_s1_q       <= seg_s1_d;
            seg_s2_q       <= seg_s2_d;
            seg_prev_q     <= seg_prev_d;
            dp_s1_q        <= dp_s1_d;
            dp_s2_unused_q <= dp_s2_unused_d;
            settle_cnt_q   <= settle_cnt_d;
            multi_cnt_q    <= multi_cnt_d;
            stale_cnt_q    <= stale_cnt_d;
            shadow_code_q  <= shadow_code_d;
            shadow_ok_q    <= shadow_ok_d;
            seen_q         <= seen_d;
            digits_q       <= digits_d;
            digit_ok_q     <= digit_ok_d;
            value_q        <= value_d;
            value_ok_q     <= value_ok_d;
            frame_strb_q   <= frame_strb_d;
            err_multi_q    <= err_multi_d;
        end
    end

    assign digits     = digits_q;
    assign digit_ok   = digit_ok_q;
    assign value      = value_q;
    assign value_ok   = value_ok_q;
    assign frame_strb = frame_strb_q;
    assign err_multi  = err_multi_q;
    assign stale      = (stale_cnt_q == STALE_MAX);

endmodule
